// File: rtl/silife_pkg.sv
// Shared constants and helpers for the Game-of-Life cell array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   NEIGH_W      width of a live-neighbour count (0..8)
//   BIRTH_COUNT  neighbour count that brings a dead cell to life
//   SURVIVE_MIN  lowest neighbour count at which a live cell survives
//   SURVIVE_MAX  highest neighbour count at which a live cell survives
//   cell_index   flat bit position of cell (x,y) in a row-major grid
package silife_pkg;

   localparam int NEIGH_W = 4;

   localparam logic [NEIGH_W-1:0] BIRTH_COUNT = 4'd3;
   localparam logic [NEIGH_W-1:0] SURVIVE_MIN = 4'd2;
   localparam logic [NEIGH_W-1:0] SURVIVE_MAX = 4'd3;

   // Row-major flattening: bit y*width+x holds cell (x,y).
   function automatic int cell_index(input int x, input int y, input int width);
      return y * width + x;
   endfunction

endpackage

// File: rtl/silife_cell_rule.sv
// Next-state rule (B3/S23) for a single Game-of-Life cell.
// Latency: purely combinational, no state.
// Backpressure: none; output follows inputs.
//
// Ports:
//   cur    in   1  current state of this cell
//   neigh  in   8  current states of the eight surrounding cells
//   nxt    out  1  state of this cell in the next generation
module silife_cell_rule
   import silife_pkg::*;
(
   input  logic       cur,
   input  logic [7:0] neigh,
   output logic       nxt
);

   logic [NEIGH_W-1:0] count;

   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + NEIGH_W'(neigh[i]);
      end

      if (cur) begin
         nxt = (count >= SURVIVE_MIN) && (count <= SURVIVE_MAX);
      end else begin
         nxt = (count == BIRTH_COUNT);
      end
   end

endmodule

// File: rtl/silife_cell_array.sv
// HEIGHT x WIDTH Game-of-Life cell register with generation stepping.
// Latency: writes and steps are visible one cycle after the input cycle.
// Backpressure: a step colliding with a write is deferred (busy=1) until the first write-free cycle.
//
// Ports:
//   clk          in   1             single clock
//   reset        in   1             synchronous, active-high
//   set_cells    in   HEIGHT*WIDTH  per-cell set strobe
//   clear_cells  in   HEIGHT*WIDTH  per-cell clear strobe (applied before set)
//   step         in   1             request one generation advance
//   cells        out  HEIGHT*WIDTH  cell state, bit y*WIDTH+x = cell (x,y)
//   generation   out  16            generations computed since reset (wraps)
//   stable       out  1             last executed step changed no cell
//   busy         out  1             a deferred step is waiting
module silife_cell_array
   import silife_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int WRAP   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [HEIGHT*WIDTH-1:0]   set_cells,
   input  logic [HEIGHT*WIDTH-1:0]   clear_cells,
   input  logic                      step,
   output logic [HEIGHT*WIDTH-1:0]   cells,
   output logic [15:0]               generation,
   output logic                      stable,
   output logic                      busy
);

   localparam int N = HEIGHT * WIDTH;

   logic [N-1:0]  cells_q,      cells_d;
   logic [15:0]   generation_q, generation_d;
   logic          stable_q,     stable_d;
   logic          pending_q,    pending_d;

   logic [N-1:0]  next_cells;
   logic          write_cyc;

   // ------------------------------------------------------------------
   // Neighbour wiring and per-cell rule. All neighbour positions are
   // resolved at elaboration time, so the wiring is plain connections.
   // ------------------------------------------------------------------
   for (genvar gy = 0; gy < HEIGHT; gy++) begin : g_row
      for (genvar gx = 0; gx < WIDTH; gx++) begin : g_col
         logic [7:0] neigh;

         for (genvar k = 0; k < 8; k++) begin : g_nb
            // k walks the 3x3 window in raster order, skipping the centre (j=4).
            localparam int J      = (k < 4) ? k : k + 1;
            localparam int NX     = gx + (J % 3) - 1;
            localparam int NY     = gy + (J / 3) - 1;
            localparam bit INSIDE = (NX >= 0) && (NX < WIDTH) && (NY >= 0) && (NY < HEIGHT);
            localparam int WX     = (NX + WIDTH) % WIDTH;
            localparam int WY     = (NY + HEIGHT) % HEIGHT;

            if ((WRAP != 0) || INSIDE) begin : g_live
               assign neigh[k] = cells_q[cell_index(WX, WY, WIDTH)];
            end else begin : g_dead
               assign neigh[k] = 1'b0;
            end
         end

         silife_cell_rule u_rule (
            .cur   (cells_q[cell_index(gx, gy, WIDTH)]),
            .neigh (neigh),
            .nxt   (next_cells[cell_index(gx, gy, WIDTH)])
         );
      end
   end

   // ------------------------------------------------------------------
   // Update control: write beats step; a step that loses to a write is
   // remembered in pending and merged with any further step requests.
   // ------------------------------------------------------------------
   assign write_cyc = (|set_cells) || (|clear_cells);

   always_comb begin
      cells_d      = cells_q;
      generation_d = generation_q;
      stable_d     = stable_q;
      pending_d    = pending_q;

      if (write_cyc) begin
         // Clear first, then set: a bit with both strobes ends up set.
         cells_d  = (cells_q & ~clear_cells) | set_cells;
         stable_d = 1'b0;
         if (step) begin
            pending_d = 1'b1;
         end
      end else if (step || pending_q) begin
         cells_d      = next_cells;
         generation_d = generation_q + 16'd1;
         stable_d     = (next_cells == cells_q);
         pending_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cells_q      <= '0;
         generation_q <= '0;
         stable_q     <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         cells_q      <= cells_d;
         generation_q <= generation_d;
         stable_q     <= stable_d;
         pending_q    <= pending_d;
      end
   end

   assign cells      = cells_q;
   assign generation = generation_q;
   assign stable     = stable_q;
   assign busy       = pending_q;

endmodule
